// File: rtl/fir_pkg.sv
// fir_driver shared constants and types.
// Widths match the 64-tap FIR core pinout.
package fir_pkg;

  localparam int NTAPS = 64;
  localparam int AW    = 6;
  localparam int DW    = 16;
  localparam int ACCW  = 41;
  localparam int CW    = 14;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARM,
    RUN,
    DONE
  } drv_state_t;

endpackage

// File: rtl/fir_driver_if.sv
// Host + core pin bundle for fir_driver.
// master = driver view, slave = host/core view.
interface fir_driver_if;
  import fir_pkg::*;

  logic            go;
  logic [CW-1:0]   run_len;
  logic            coef_valid;
  logic            coef_ready;
  logic [DW-1:0]   coef_data;
  logic            samp_valid;
  logic            samp_ready;
  logic [DW-1:0]   samp_data;
  logic            cload;
  logic [AW-1:0]   caddr;
  logic [DW-1:0]   cin;
  logic            start;
  logic [DW-1:0]   din;
  logic            valid_in;
  logic            valid_out;
  logic [ACCW-1:0] dout;
  logic            result_valid;
  logic [ACCW-1:0] result_data;
  logic            busy;
  logic            done;
  logic            underrun;

  modport master (
    input  go, run_len,
    input  coef_valid, coef_data,
    input  samp_valid, samp_data,
    input  valid_out, dout,
    output coef_ready, samp_ready,
    output cload, caddr, cin, start,
    output din, valid_in,
    output result_valid, result_data,
    output busy, done, underrun
  );

  modport slave (
    output go, run_len,
    output coef_valid, coef_data,
    output samp_valid, samp_data,
    output valid_out, dout,
    input  coef_ready, samp_ready,
    input  cload, caddr, cin, start,
    input  din, valid_in,
    input  result_valid, result_data,
    input  busy, done, underrun
  );

endinterface

// File: rtl/fir_driver_edge_det.sv
// One-bit rise/fall detector with a
// registered history and sync clear.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic hist_q;
  logic hist_d;

  always_comb begin
    hist_d = clr ? 1'b0 : d;
  end

  always_ff @(posedge clk) begin
    if (rst) hist_q <= 1'b0;
    else     hist_q <= hist_d;
  end

  assign rise = d & ~hist_q;
  assign fall = ~d & hist_q;

endmodule

// File: rtl/fir_driver.sv
// Host-side driver for the 64-tap FIR core:
// coef load, start, sample pacing, result dedup.
module fir_driver
  import fir_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  fir_driver_if.master bus
);

  drv_state_t      state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   len_q, len_d;
  logic            cload_q, cload_d;
  logic [AW-1:0]   caddr_q, caddr_d;
  logic [DW-1:0]   cin_q, cin_d;
  logic            start_q, start_d;
  logic [DW-1:0]   din_q, din_d;
  logic            full_q, full_d;
  logic            rv_q, rv_d;
  logic [ACCW-1:0] rdata_q, rdata_d;
  logic            done_q, done_d;
  logic            unr_q, unr_d;

  logic          rise, fall;
  logic          in_run, consume;
  logic          samp_rdy, samp_acc;
  logic          coef_acc;
  logic [CW-1:0] len_m1;

  // History held clear in IDLE so a run
  // never sees a stale valid_out edge.
  edge_det u_vo_edge (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == IDLE),
    .d    (bus.valid_out),
    .rise (rise),
    .fall (fall)
  );

  assign in_run   = (state_q == RUN);
  assign consume  = in_run & fall;
  assign samp_rdy = in_run & (~full_q | consume);
  assign samp_acc = samp_rdy & bus.samp_valid;
  assign coef_acc = (state_q == LOAD)
                  & bus.coef_valid;
  assign len_m1   = len_q - 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    cload_d = 1'b0;
    caddr_d = caddr_q;
    cin_d   = cin_q;
    start_d = 1'b0;
    din_d   = din_q;
    full_d  = full_q;
    rv_d    = 1'b0;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    unr_d   = unr_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (bus.go) begin
          len_d   = bus.run_len;
          idx_d   = '0;
          cnt_d   = '0;
          unr_d   = 1'b0;
          state_d = LOAD;
        end
      end
      (state_q == LOAD): begin
        if (coef_acc) begin
          cload_d = 1'b1;
          caddr_d = idx_q;
          cin_d   = bus.coef_data;
          idx_d   = idx_q + 1'b1;
          if (idx_q == AW'(NTAPS - 1))
            state_d = ARM;
        end
      end
      (state_q == ARM): begin
        start_d = 1'b1;
        state_d = RUN;
      end
      (state_q == RUN): begin
        // Same-cycle accept wins over consume.
        if (samp_acc) begin
          din_d  = bus.samp_data;
          full_d = 1'b1;
        end else if (consume) begin
          full_d = 1'b0;
        end
        if (consume && !full_q)
          unr_d = 1'b1;
        if (rise) begin
          rv_d    = 1'b1;
          rdata_d = bus.dout;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == len_m1)
            state_d = DONE;
        end
      end
      (state_q == DONE): begin
        done_d  = 1'b1;
        full_d  = 1'b0;
        din_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      cload_q <= 1'b0;
      caddr_q <= '0;
      cin_q   <= '0;
      start_q <= 1'b0;
      din_q   <= '0;
      full_q  <= 1'b0;
      rv_q    <= 1'b0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      unr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      cload_q <= cload_d;
      caddr_q <= caddr_d;
      cin_q   <= cin_d;
      start_q <= start_d;
      din_q   <= din_d;
      full_q  <= full_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      unr_q   <= unr_d;
    end
  end

  assign bus.coef_ready   = (state_q == LOAD);
  assign bus.samp_ready   = samp_rdy;
  assign bus.cload        = cload_q;
  assign bus.caddr        = caddr_q;
  assign bus.cin          = cin_q;
  assign bus.start        = start_q;
  assign bus.din          = din_q;
  assign bus.valid_in     = full_q;
  assign bus.result_valid = rv_q;
  assign bus.result_data  = rdata_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = done_q;
  assign bus.underrun     = unr_q;

endmodule

// File: tb/tb_fir_driver.sv
// Scoreboard bench for fir_driver: coef
// writes and results checked from queues.
module tb_fir_driver;
  import fir_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fir_driver_if bus ();

  fir_driver u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int cload_cnt = 0;
  int done_cnt = 0;

  logic [AW+DW-1:0] cq[$];
  logic [ACCW-1:0]  rq[$];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (bus.cload) begin
      cload_cnt++;
      if (cq.size() == 0) begin
        chk("cload_extra", 64'(bus.cload), 0);
      end else begin
        e = cq.pop_front();
        chk("caddr", 64'(bus.caddr),
            64'(e[AW+DW-1:DW]));
        chk("cin", 64'(bus.cin),
            64'(e[DW-1:0]));
      end
    end
    if (bus.result_valid) begin
      if (rq.size() == 0)
        chk("res_extra",
            64'(bus.result_valid), 0);
      else
        chk("result",
            64'(bus.result_data),
            64'(rq.pop_front()));
    end
    if (bus.done) done_cnt++;
  end

  task automatic go_run(input logic [CW-1:0] len);
    bus.run_len = len;
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
  endtask

  task automatic load(input int stop_at);
    cload_cnt = 0;
    for (int k = 0; k < stop_at; k++) begin
      if (k == 20) begin
        bus.coef_valid = 1'b0;
        repeat (3) tick();
      end
      bus.coef_valid = 1'b1;
      bus.coef_data = DW'(k + 1);
      if (k == 0)
        chk("coef_ready", 64'(bus.coef_ready), 1);
      if (bus.coef_ready)
        cq.push_back({AW'(k), DW'(k + 1)});
      tick();
      if (k == 0)
        chk("caddr_first", 64'(bus.caddr), 0);
    end
    bus.coef_valid = 1'b0;
    if (stop_at == NTAPS) begin
      tick();
      chk("start", 64'(bus.start), 1);
      chk("cload_cnt", 64'(cload_cnt), 64);
      tick();
      chk("start_1shot", 64'(bus.start), 0);
    end
  endtask

  task automatic pulse(input logic [ACCW-1:0] v);
    bus.valid_out = 1'b1;
    bus.dout = v;
    rq.push_back(v);
    tick();
    bus.valid_out = 1'b0;
    tick();
  endtask

  task automatic last_pulse(input logic [ACCW-1:0] v);
    bus.valid_out = 1'b1;
    bus.dout = v;
    rq.push_back(v);
    tick();
    chk("last_rv", 64'(bus.result_valid), 1);
    chk("last_nodone", 64'(bus.done), 0);
    chk("last_busy", 64'(bus.busy), 1);
    bus.valid_out = 1'b0;
    tick();
    chk("done", 64'(bus.done), 1);
    chk("idle_busy", 64'(bus.busy), 0);
    tick();
    chk("done_1shot", 64'(bus.done), 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.go = 1'b0;
    bus.run_len = '0;
    bus.coef_valid = 1'b0;
    bus.coef_data = '0;
    bus.samp_valid = 1'b0;
    bus.samp_data = '0;
    bus.valid_out = 1'b0;
    bus.dout = '0;
    repeat (3) tick();
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_cload", 64'(bus.cload), 0);
    chk("rst_caddr", 64'(bus.caddr), 0);
    chk("rst_vin", 64'(bus.valid_in), 0);
    chk("rst_unr", 64'(bus.underrun), 0);
    chk("rst_rv", 64'(bus.result_valid), 0);
    rst = 1'b0;
    tick();

    // run 1: load, dedup, pacing, underrun
    go_run(14'd4);
    load(NTAPS);
    bus.samp_valid = 1'b1;
    bus.samp_data = 16'h0011;
    #1;
    chk("srdy_empty", 64'(bus.samp_ready), 1);
    tick();
    bus.samp_valid = 1'b0;
    chk("din_pre", 64'(bus.din), 64'h11);
    chk("vin_pre", 64'(bus.valid_in), 1);

    bus.valid_out = 1'b1;
    bus.dout = 41'h1_2345_6789;
    rq.push_back(41'h1_2345_6789);
    tick();
    chk("rv_rise", 64'(bus.result_valid), 1);
    repeat (4) begin
      tick();
      chk("rv_hold", 64'(bus.result_valid), 0);
    end

    bus.valid_out = 1'b0;
    bus.samp_valid = 1'b1;
    bus.samp_data = 16'h0022;
    #1;
    chk("srdy_cons", 64'(bus.samp_ready), 1);
    tick();
    bus.samp_valid = 1'b0;
    chk("din_swap", 64'(bus.din), 64'h22);
    chk("vin_swap", 64'(bus.valid_in), 1);
    chk("unr_swap", 64'(bus.underrun), 0);

    pulse(41'h0AB_CDEF_0123);
    chk("vin_drain", 64'(bus.valid_in), 0);
    chk("unr_drain", 64'(bus.underrun), 0);
    pulse(41'h1FF_0000_0001);
    chk("unr_set", 64'(bus.underrun), 1);
    tick();
    chk("unr_sticky", 64'(bus.underrun), 1);
    last_pulse(41'h000_0000_0BEE);

    // run 2: run_len = 3, go clears underrun
    go_run(14'd3);
    chk("unr_clr", 64'(bus.underrun), 0);
    load(NTAPS);
    for (int i = 0; i < 2; i++)
      pulse(ACCW'(i + 100));
    last_pulse(41'h0_00C0_FFEE);

    // run 3: run_len = 0 means 2^CW results
    go_run(14'd0);
    load(NTAPS);
    done_cnt = 0;
    for (int i = 0; i < 16384; i++) begin
      if (i == 16383) begin
        chk("len0_busy", 64'(bus.busy), 1);
        chk("len0_early", 64'(done_cnt), 0);
      end
      pulse(ACCW'(i) ^ 41'h155_5555_5555);
    end
    chk("len0_done", 64'(bus.done), 1);
    tick();

    // reset in the middle of a coef load
    go_run(14'd5);
    load(30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_cload", 64'(bus.cload), 0);
    chk("mid_caddr", 64'(bus.caddr), 0);
    chk("mid_busy", 64'(bus.busy), 0);
    chk("mid_crdy", 64'(bus.coef_ready), 0);
    chk("mid_cq", 64'(cq.size()), 0);
    tick();
    go_run(14'd5);
    load(NTAPS);
    repeat (3) tick();
    chk("cq_left", 64'(cq.size()), 0);
    chk("rq_left", 64'(rq.size()), 0);

    $display("CHECKS %0d ERRORS %0d",
             n_chk, n_err);
    $finish;
  end

endmodule
